// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths, requester ids and read-tag type for the RAM port arbiter
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DFLT       = 16;
    localparam int DATA_W_DFLT       = 16;
    localparam int STARVE_LIMIT_DFLT = 4;
    localparam int STARVE_CNT_W      = 8;

    typedef enum logic {
        RQ_CPU = 1'b0,
        RQ_DMA = 1'b1
    } rq_id_e;

    typedef struct packed {
        logic   valid;
        rq_id_e id;
    } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// rtl/mem_port_arbiter_starve_counter.sv - saturating denial counter that flags when the DMA must be let through
module mem_port_arbiter_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int CNT_W = STARVE_CNT_W,
    parameter int LIMIT = STARVE_LIMIT_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester RAM port arbiter, CPU priority with DMA starvation guard
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DFLT,
    parameter int DATA_W       = DATA_W_DFLT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic    at_limit;
    logic    gnt0_c;
    logic    gnt1_c;
    rd_tag_t tag_q;
    rd_tag_t tag_d;

    mem_port_arbiter_starve_counter #(
        .CNT_W (STARVE_CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (req1 && !gnt1_c),
        .clr      (gnt1_c),
        .at_limit (at_limit)
    );

    // Grants are held low during reset so nothing reaches the RAM port.
    always_comb begin
        gnt1_c    = !reset && req1 && (!req0 || at_limit);
        gnt0_c    = !reset && req0 && !gnt1_c;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        tag_d     = '0;
        if (gnt1_c) begin
            ram_we    = we1;
            ram_addr  = addr1;
            ram_wdata = wdata1;
            tag_d     = '{valid: !we1, id: RQ_DMA};
        end else if (gnt0_c) begin
            ram_we    = we0;
            ram_addr  = addr0;
            ram_wdata = wdata0;
            tag_d     = '{valid: !we0, id: RQ_CPU};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    // A tag still set while reset is high belongs to an aborted read; suppress it.
    assign gnt0    = gnt0_c;
    assign gnt1    = gnt1_c;
    assign rvalid0 = !reset && tag_q.valid && (tag_q.id == RQ_CPU);
    assign rvalid1 = !reset && tag_q.valid && (tag_q.id == RQ_DMA);
    assign rdata0  = ram_rdata;
    assign rdata1  = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector table plus randomized run against a behavioural arbiter model
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, ram_we;
    logic [15:0] rdata0, rdata1, ram_addr, ram_wdata;
    logic [15:0] ram_rdata;

    int checks = 0;
    int failures = 0;

    logic [15:0] ram [0:65535];
    logic [15:0] mdl [0:65535];

    int          m_cnt = 0;
    bit          p_valid = 1'b0;
    bit          p_dma = 1'b0;
    logic [15:0] p_data = '0;

    typedef struct packed {
        logic        rst;
        logic        r0;
        logic        w0;
        logic [15:0] a0;
        logic [15:0] d0;
        logic        r1;
        logic        w1;
        logic [15:0] a1;
        logic [15:0] d1;
        logic        g0;
        logic        g1;
        logic        we;
        logic        rv0;
        logic        rv1;
        logic [15:0] rd;
    } vec_t;

    vec_t tbl[$];

    mem_port_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (16),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rvalid0   (rvalid0),
        .rdata0    (rdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata1    (rdata1),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Registered, read-before-write RAM.
    always @(posedge clk) begin
        ram_rdata <= ram[ram_addr];
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add_v(input logic rst, input logic r0, input logic w0, input logic [15:0] a0,
                         input logic [15:0] d0, input logic r1, input logic w1, input logic [15:0] a1,
                         input logic [15:0] d1, input logic g0, input logic g1, input logic we,
                         input logic rv0, input logic rv1, input logic [15:0] rd);
        vec_t v;
        v = '{rst, r0, w0, a0, d0, r1, w1, a1, d1, g0, g1, we, rv0, rv1, rd};
        tbl.push_back(v);
    endtask

    task automatic step(input vec_t v, input bit use_tbl);
        bit          eg0, eg1, ewe, erv0, erv1;
        logic [15:0] eaddr, ewd;
        @(negedge clk);
        reset = v.rst;
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
        #1;
        eg0 = 0; eg1 = 0; ewe = 0; eaddr = '0; ewd = '0; erv0 = 0; erv1 = 0;
        if (!v.rst) begin
            if (v.r1 && (!v.r0 || m_cnt == LIMIT)) eg1 = 1;
            else if (v.r0) eg0 = 1;
            if (eg1) begin ewe = v.w1; eaddr = v.a1; ewd = v.d1; end
            if (eg0) begin ewe = v.w0; eaddr = v.a0; ewd = v.d0; end
            erv0 = p_valid && !p_dma;
            erv1 = p_valid && p_dma;
        end
        chk("gnt0", 16'(gnt0), 16'(eg0));
        chk("gnt1", 16'(gnt1), 16'(eg1));
        chk("both_gnt", 16'(gnt0 & gnt1), 16'h0);
        chk("ram_we", 16'(ram_we), 16'(ewe));
        chk("ram_addr", ram_addr, eaddr);
        chk("ram_wdata", ram_wdata, ewd);
        chk("rvalid0", 16'(rvalid0), 16'(erv0));
        chk("rvalid1", 16'(rvalid1), 16'(erv1));
        chk("starve_cnt", 16'(dut.u_starve.cnt_q), 16'(m_cnt));
        if (erv0 || erv1) begin
            chk("rdata0", rdata0, p_data);
            chk("rdata1", rdata1, p_data);
        end
        if (use_tbl) begin
            chk("tbl_gnt0", 16'(gnt0), 16'(v.g0));
            chk("tbl_gnt1", 16'(gnt1), 16'(v.g1));
            chk("tbl_ram_we", 16'(ram_we), 16'(v.we));
            chk("tbl_rvalid0", 16'(rvalid0), 16'(v.rv0));
            chk("tbl_rvalid1", 16'(rvalid1), 16'(v.rv1));
            if (v.rv0) chk("tbl_rdata0", rdata0, v.rd);
            if (v.rv1) chk("tbl_rdata1", rdata1, v.rd);
        end
        if (v.rst) begin
            m_cnt = 0;
            p_valid = 0;
        end else begin
            p_valid = (eg0 || eg1) && !ewe;
            p_dma = eg1;
            p_data = mdl[eaddr];
            if ((eg0 || eg1) && ewe) mdl[eaddr] = ewd;
            if (eg1) m_cnt = 0;
            else if (v.r1 && m_cnt < LIMIT) m_cnt++;
        end
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 16'(i) ^ 16'h5A5A;
            mdl[i] = 16'(i) ^ 16'h5A5A;
        end
        ram[16'h0200] = 16'h1234; mdl[16'h0200] = 16'h1234;
        ram[16'h0001] = 16'hAAAA; mdl[16'h0001] = 16'hAAAA;
        ram[16'h0002] = 16'h5555; mdl[16'h0002] = 16'h5555;

        // rst r0 w0 a0 d0 r1 w1 a1 d1 | g0 g1 we rv0 rv1 rd
        add_v(1, 1, 0, 16'h0, 16'h0, 1, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
        add_v(1, 1, 0, 16'h0, 16'h0, 1, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
        add_v(0, 1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0, 16'h0, 1, 0, 1, 0, 0, 16'h0);
        add_v(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 0, 0, 16'h0);
        add_v(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 1, 0, 16'hBEEF);
        add_v(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0200, 16'h0, 0, 1, 0, 0, 0, 16'h0);
        add_v(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 1, 16'h1234);
        add_v(0, 1, 0, 16'h0001, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 0, 0, 16'h0);
        add_v(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0002, 16'h0, 0, 1, 0, 1, 0, 16'hAAAA);
        add_v(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 1, 16'h5555);
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4)
                add_v(0, 1, 1, 16'h0100, 16'(k), 1, 1, 16'h0101, 16'(k), 0, 1, 1, 0, 0, 16'h0);
            else
                add_v(0, 1, 1, 16'h0100, 16'(k), 1, 1, 16'h0101, 16'(k), 1, 0, 1, 0, 0, 16'h0);
        end
        add_v(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
        add_v(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 0, 0, 16'h0);
        add_v(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
        add_v(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
        add_v(0, 1, 1, 16'h0010, 16'hCAFE, 0, 0, 16'h0, 16'h0, 1, 0, 1, 0, 0, 16'h0);
        add_v(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 0, 0, 16'h0);
        add_v(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 1, 0, 16'hCAFE);

        foreach (tbl[i]) step(tbl[i], 1'b1);

        // Read then write to the same address back-to-back returns the old value.
        v = '0; v.r0 = 1; v.a0 = 16'h0030; step(v, 1'b0);
        v = '0; v.r1 = 1; v.w1 = 1; v.a1 = 16'h0030; v.d1 = 16'h7777; step(v, 1'b0);
        v = '0; v.r0 = 1; v.a0 = 16'h0030; step(v, 1'b0);
        v = '0; step(v, 1'b0);

        for (int n = 0; n < 800; n++) begin
            v = '0;
            v.rst = ($urandom_range(0, 63) == 0);
            v.r0 = ($urandom_range(0, 3) != 0);
            v.w0 = $urandom_range(0, 1) == 1;
            v.a0 = 16'($urandom_range(0, 7));
            v.d0 = 16'($urandom);
            v.r1 = $urandom_range(0, 1) == 1;
            v.w1 = $urandom_range(0, 1) == 1;
            v.a1 = 16'($urandom_range(0, 7));
            v.d1 = 16'($urandom);
            step(v, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
